// File: rtl/mem_dbus_ctrl_pkg.sv
// mem_dbus_ctrl_pkg: shared state encodings, bus size codes and memtype bit indices for the data-bus controller
package mem_dbus_ctrl_pkg;
    typedef enum logic [2:0] {DBUS_IDLE, DBUS_REQ, DBUS_WAIT, DBUS_DONE, DBUS_ERR} dbus_state_t;
    localparam logic [1:0] DBUS_SIZE_B = 2'd0;
    localparam logic [1:0] DBUS_SIZE_H = 2'd1;
    localparam logic [1:0] DBUS_SIZE_W = 2'd2;
    localparam int MT_LB  = 0;
    localparam int MT_LBU = 1;
    localparam int MT_LH  = 2;
    localparam int MT_LHU = 3;
    localparam int MT_LW  = 4;
    localparam int MT_SB  = 5;
    localparam int MT_SH  = 6;
    localparam int MT_SW  = 7;
    function automatic logic [1:0] size_of(input logic [7:0] mt);
        return (mt[MT_LB] | mt[MT_LBU] | mt[MT_SB]) ? DBUS_SIZE_B :
               (mt[MT_LH] | mt[MT_LHU] | mt[MT_SH]) ? DBUS_SIZE_H : DBUS_SIZE_W;
    endfunction
endpackage

// File: rtl/dbus_load_ext.sv
// dbus_load_ext: byte/half lane select and sign/zero extension of a held load word
//   rdata   in  32  raw bus read data
//   addr    in  2   low address bits selecting the lane
//   ld_type in  5   one-hot {lw,lhu,lh,lbu,lb}
//   ld_data out 32  extended result, 0 when no load type is set
module dbus_load_ext
    import mem_dbus_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [4:0]  ld_type,
    output logic [31:0] ld_data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16]) : (addr[0] ? rdata[15:8] : rdata[7:0]);
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];
    assign ld_data = ld_type[MT_LB]  ? {{24{b[7]}}, b}  :
                     ld_type[MT_LBU] ? {24'b0, b}       :
                     ld_type[MT_LH]  ? {{16{h[15]}}, h} :
                     ld_type[MT_LHU] ? {16'b0, h}       :
                     ld_type[MT_LW]  ? rdata            : 32'b0;
endmodule

// File: rtl/mem_dbus_ctrl.sv
// mem_dbus_ctrl: memory-stage data-bus handshake controller (SRAM-like req/addr_ok/data_ok) with pipeline stall and load extension
//   clk, resetn                    clock, async active-low reset
//   mem_dce_i/daddr/we/din/dre/memtype, mem_exc_i, flush_i   access request from the memory stage
//   data_req/wr/size/addr/wstrb/wdata_o, data_addr_ok/data_ok/rdata_i   SRAM-like data bus
//   stall_o, ld_valid_o, ld_data_o, bus_err_o                pipeline side results
//   Optional macro DBUS_TIMEOUT_EN adds a bus-wait timeout (ERR state, bus_err_o pulse).
module mem_dbus_ctrl
    import mem_dbus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_dce_i,
    input  logic [31:0] mem_daddr_i,
    input  logic [3:0]  mem_we_i,
    input  logic [31:0] mem_din_i,
    input  logic [3:0]  mem_dre_i,
    input  logic [7:0]  mem_memtype_i,
    input  logic        mem_exc_i,
    input  logic        flush_i,
    output logic        data_req_o,
    output logic        data_wr_o,
    output logic [1:0]  data_size_o,
    output logic [31:0] data_addr_o,
    output logic [3:0]  data_wstrb_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_addr_ok_i,
    input  logic        data_data_ok_i,
    input  logic [31:0] data_rdata_i,
    output logic        stall_o,
    output logic        ld_valid_o,
    output logic [31:0] ld_data_o,
    output logic        bus_err_o
);
    if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end
    dbus_state_t state;
    logic [31:0] addr_q, din_q, rdata_q, ext;
    logic [3:0]  we_q, dre_q;
    logic [7:0]  mt_q;
    logic [1:0]  size_q;
    logic        flushed, start, busy, to;
    assign start = mem_dce_i & ~mem_exc_i & ~flush_i;
    assign busy  = (state == DBUS_REQ) | (state == DBUS_WAIT);
`ifdef DBUS_TIMEOUT_EN
    logic [CNT_W-1:0] cnt;
    // data_ok arriving on the timeout cycle still completes the transfer
    assign to        = (cnt >= CNT_W'(TIMEOUT_CYCLES)) & ~data_data_ok_i;
    assign bus_err_o = state == DBUS_ERR;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt <= '0;
        else cnt <= (state == DBUS_IDLE) ? '0 : busy ? cnt + 1'b1 : cnt;
`else
    assign to        = 1'b0;
    assign bus_err_o = 1'b0;
`endif
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= DBUS_IDLE;
            addr_q  <= '0;
            din_q   <= '0;
            we_q    <= '0;
            dre_q   <= '0;
            mt_q    <= '0;
            size_q  <= '0;
            rdata_q <= '0;
            flushed <= 1'b0;
        end else begin
            case (state)
                DBUS_IDLE: begin
                    flushed <= 1'b0;
                    if (start) begin
                        addr_q <= mem_daddr_i;
                        din_q  <= mem_din_i;
                        we_q   <= mem_we_i;
                        dre_q  <= mem_dre_i;
                        mt_q   <= mem_memtype_i;
                        size_q <= size_of(mem_memtype_i);
                        state  <= DBUS_REQ;
                    end
                end
                DBUS_REQ: begin
                    flushed <= flushed | flush_i;
                    if (data_data_ok_i) rdata_q <= data_rdata_i;
                    if (data_addr_ok_i & data_data_ok_i) state <= DBUS_DONE;
                    else if (to) state <= DBUS_ERR;
                    else if (data_addr_ok_i) state <= DBUS_WAIT;
                end
                DBUS_WAIT: begin
                    flushed <= flushed | flush_i;
                    if (data_data_ok_i) rdata_q <= data_rdata_i;
                    state <= data_data_ok_i ? DBUS_DONE : to ? DBUS_ERR : DBUS_WAIT;
                end
                default: state <= DBUS_IDLE;
            endcase
        end
    end
    dbus_load_ext u_ext (
        .rdata   (rdata_q),
        .addr    (addr_q[1:0]),
        .ld_type (mt_q[MT_LW:MT_LB]),
        .ld_data (ext)
    );
    assign data_req_o   = state == DBUS_REQ;
    assign data_wr_o    = |we_q;
    assign data_size_o  = size_q;
    assign data_addr_o  = addr_q;
    // reads present their byte enables on the strobe lanes
    assign data_wstrb_o = data_wr_o ? we_q : dre_q;
    assign data_wdata_o = din_q;
    assign stall_o      = ((state == DBUS_IDLE) & start) | busy;
    assign ld_valid_o   = (state == DBUS_DONE) & (|mt_q[MT_LW:MT_LB]) & ~flushed;
    assign ld_data_o    = (state == DBUS_DONE) ? ext : 32'b0;
endmodule
